// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states,
// the default ack timeout and the access legality rule.
package load_store_unit_pkg;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    localparam int unsigned DefaultAckTimeout = 255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } lsu_state_e;

    // Stores accept only signed-size codes; halves and words must be naturally aligned.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            Funct3B:  ok = 1'b1;
            Funct3Bu: ok = !is_store;
            Funct3H:  ok = !addr_lo[0];
            Funct3Hu: ok = !is_store && !addr_lo[0];
            Funct3W:  ok = (addr_lo == 2'b00);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store byte enables and data replication, load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
        case (st_funct3_i)
            Funct3B: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            Funct3H: begin
                st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_wdata_i;
            end
        endcase
    end

    always_comb begin
        byte_sel = ld_word_i[7:0];
        case (ld_addr_lo_i)
            2'd1:    byte_sel = ld_word_i[15:8];
            2'd2:    byte_sel = ld_word_i[23:16];
            2'd3:    byte_sel = ld_word_i[31:24];
            default: byte_sel = ld_word_i[7:0];
        endcase
        half_sel = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        case (ld_funct3_i)
            Funct3B:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            Funct3Bu: ld_data_o = {24'h0, byte_sel};
            Funct3H:  ld_data_o = {{16{half_sel[15]}}, half_sel};
            Funct3Hu: ld_data_o = {16'h0, half_sel};
            default:  ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory access at a time from decode, stalls the
// pipeline while the data memory handshake is outstanding, and times out a missing ack.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = DefaultAckTimeout
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        access_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        timeout_q, timeout_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        legal;

    lsu_align u_align (
        .st_funct3_i  (funct3),
        .st_addr_lo_i (addr[1:0]),
        .st_wdata_i   (wdata),
        .st_be_o      (st_be),
        .st_wdata_o   (st_wdata),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_word_i    (dmem_rdata),
        .ld_data_o    (ld_data)
    );

    assign legal = access_legal(mem_write, funct3, addr[1:0]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        timeout_d    = timeout_q;
        rdata_d      = rdata_q;
        stall        = 1'b0;
        access_err   = 1'b0;
        rdata_valid  = 1'b0;
        bus_err      = 1'b0;

        case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    if ((mem_read && mem_write) || !legal) begin
                        access_err = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        state_d      = StBusy;
                        cnt_d        = 8'd0;
                        timeout_d    = 1'b0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = mem_write;
                        dmem_addr_d  = {addr[31:2], 2'b00};
                        dmem_be_d    = mem_write ? st_be : 4'b0000;
                        dmem_wdata_d = st_wdata;
                        is_load_d    = mem_read;
                        funct3_d     = funct3;
                        addr_lo_d    = addr[1:0];
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    if (is_load_q) begin
                        rdata_d = ld_data;
                    end
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                rdata_valid = is_load_q && !timeout_q;
                bus_err     = timeout_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Idle-state outputs depend on live inputs; keep them quiet while reset is held.
        if (rst) begin
            stall      = 1'b0;
            access_err = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_wdata_q <= 32'h0;
            dmem_be_q    <= 4'b0000;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            timeout_q    <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            timeout_q    <= timeout_d;
            rdata_q      <= rdata_d;
        end
    end

    assign rdata      = rdata_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_be    = dmem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory responder with programmable
// ack delay, scoreboard queue of expected load data.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        access_err;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata = 32'h0;

    load_store_unit #(.ACK_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .access_err  (access_err),
        .bus_err     (bus_err),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One legal access; ack_at = BUSY cycle index of the ack, -1 for none.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int ack_at,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_rdata);
        int  stall_cnt = 0;
        int  req_cycles = 0;
        bit  seen_valid = 0;
        bit  seen_berr = 0;
        bit  finished = 0;
        bit  exp_berr = (ack_at < 0);
        int  exp_req = exp_berr ? 4 : ack_at + 1;
        logic [31:0] e;
        if (rd && !exp_berr) begin
            exp_q.push_back(exp_rdata);
            last_rdata = exp_rdata;
        end
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    total++;
                    if (dmem_addr !== exp_addr || dmem_be !== exp_be || dmem_we !== wr ||
                        (wr && dmem_wdata !== exp_wd)) begin
                        bad++;
                        $display("FAIL %s bus: addr=%h be=%b we=%b wd=%h want addr=%h be=%b we=%b wd=%h",
                                 name, dmem_addr, dmem_be, dmem_we, dmem_wdata,
                                 exp_addr, exp_be, wr, exp_wd);
                    end
                end
                dmem_ack   = (req_cycles - 1 == ack_at);
                dmem_rdata = rword;
            end else begin
                dmem_ack = 1'b0;
            end
            if (bus_err) seen_berr = 1;
            if (rdata_valid) begin
                seen_valid = 1;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s unexpected rdata_valid rdata=%h", name, rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        bad++;
                        $display("FAIL %s rdata: got %h want %h", name, rdata, e);
                    end
                end
            end
            if (req_cycles > 0 && !stall) begin
                finished = 1;
                @(posedge clk);
                #1;
                mem_read = 0; mem_write = 0; dmem_ack = 0;
                break;
            end
        end
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s timeout: transaction never completed", name);
            @(posedge clk); #1;
            mem_read = 0; mem_write = 0; dmem_ack = 0;
        end
        total++;
        if (stall_cnt != exp_req + 1 || req_cycles != exp_req) begin
            bad++;
            $display("FAIL %s timing: stall=%0d req=%0d want stall=%0d req=%0d",
                     name, stall_cnt, req_cycles, exp_req + 1, exp_req);
        end
        total++;
        if (seen_berr != exp_berr || seen_valid != (rd && !exp_berr)) begin
            bad++;
            $display("FAIL %s pulses: bus_err=%0d valid=%0d want bus_err=%0d valid=%0d",
                     name, seen_berr, seen_valid, exp_berr, rd && !exp_berr);
        end
    endtask

    task automatic test_reset;
        rst = 1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
        dmem_ack = 0; dmem_rdata = 0;
        @(negedge clk);
        total++;
        if ({dmem_req, dmem_we, dmem_be, stall, rdata_valid, access_err, bus_err} !== 10'b0 ||
            dmem_addr !== 0 || dmem_wdata !== 0 || rdata !== 0) begin
            bad++;
            $display("FAIL reset: req=%b we=%b be=%b stall=%b addr=%h wd=%h rdata=%h want all zero",
                     dmem_req, dmem_we, dmem_be, stall, dmem_addr, dmem_wdata, rdata);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_store;
        run_txn("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0,
                32'h100, 4'b1111, 32'hDEADBEEF, 0);
        run_txn("sh", 0, 1, 3'b001, 32'h002, 32'h0000ABCD, 0, 1,
                32'h000, 4'b1100, 32'hABCDABCD, 0);
        run_txn("sb", 0, 1, 3'b000, 32'h301, 32'h55667712, 0, 1,
                32'h300, 4'b0010, 32'h12121212, 0);
    endtask

    task automatic test_loads;
        run_txn("lb", 1, 0, 3'b000, 32'h203, 0, 32'h80FFFF7F, 0,
                32'h200, 4'b0000, 0, 32'hFFFFFF80);
        run_txn("lbu", 1, 0, 3'b100, 32'h203, 0, 32'h80FFFF7F, 0,
                32'h200, 4'b0000, 0, 32'h00000080);
        run_txn("lb0", 1, 0, 3'b000, 32'h200, 0, 32'h80FFFF7F, 1,
                32'h200, 4'b0000, 0, 32'h0000007F);
        run_txn("lh", 1, 0, 3'b001, 32'h012, 0, 32'h80011234, 0,
                32'h010, 4'b0000, 0, 32'hFFFF8001);
        run_txn("lhu", 1, 0, 3'b101, 32'h012, 0, 32'h80011234, 0,
                32'h010, 4'b0000, 0, 32'h00008001);
        run_txn("lw", 1, 0, 3'b010, 32'h104, 0, 32'h12345678, 2,
                32'h104, 4'b0000, 0, 32'h12345678);
    endtask

    task automatic test_rdata_hold;
        run_txn("sw_hold", 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 0,
                32'h40, 4'b1111, 32'hCAFEF00D, 0);
        @(negedge clk);
        total++;
        if (rdata !== last_rdata) begin
            bad++;
            $display("FAIL rdata_hold: got %h want %h", rdata, last_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_access_err;
        logic [4:0] rows [5];
        logic [31:0] addrs [5];
        rows[0] = {1'b1, 1'b0, 3'b010}; addrs[0] = 32'h101;
        rows[1] = {1'b1, 1'b1, 3'b010}; addrs[1] = 32'h100;
        rows[2] = {1'b0, 1'b1, 3'b001}; addrs[2] = 32'h001;
        rows[3] = {1'b0, 1'b1, 3'b100}; addrs[3] = 32'h000;
        rows[4] = {1'b1, 1'b0, 3'b011}; addrs[4] = 32'h000;
        for (int i = 0; i < 5; i++) begin
            {mem_read, mem_write, funct3} = rows[i];
            addr = addrs[i]; wdata = 32'h1;
            @(negedge clk);
            total++;
            if (access_err !== 1'b1 || stall !== 1'b0 || dmem_req !== 1'b0) begin
                bad++;
                $display("FAIL access_err[%0d]: err=%b stall=%b req=%b want 1 0 0",
                         i, access_err, stall, dmem_req);
            end
            @(posedge clk); #1;
            mem_read = 0; mem_write = 0;
            @(negedge clk);
            total++;
            if (access_err !== 1'b0 || dmem_req !== 1'b0) begin
                bad++;
                $display("FAIL access_err_after[%0d]: err=%b req=%b want 0 0",
                         i, access_err, dmem_req);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout;
        run_txn("timeout", 1, 0, 3'b010, 32'h100, 0, 32'hAAAA5555, -1,
                32'h100, 4'b0000, 0, 0);
        dmem_ack = 1; dmem_rdata = 32'hAAAA5555;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (rdata_valid !== 0 || dmem_req !== 0 || bus_err !== 0) begin
                bad++;
                $display("FAIL late_ack[%0d]: valid=%b req=%b bus_err=%b want 0 0 0",
                         i, rdata_valid, dmem_req, bus_err);
            end
        end
        @(posedge clk); #1;
        dmem_ack = 0;
    endtask

    task automatic test_reset_busy;
        mem_read = 1; funct3 = 3'b010; addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (dmem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_busy_req: got %b want 1", dmem_req);
        end
        @(posedge clk); #1;
        rst = 1;
        #1;
        total++;
        if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy_drop: req=%b stall=%b want 0 0", dmem_req, stall);
        end
        mem_read = 0;
        @(posedge clk); #1;
        rst = 0;
        last_rdata = 32'h0;
        dmem_ack = 1; dmem_rdata = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rdata_valid !== 0 || dmem_req !== 0 || rdata !== 32'h0) begin
                bad++;
                $display("FAIL rst_late_ack[%0d]: valid=%b req=%b rdata=%h want 0 0 0",
                         i, rdata_valid, dmem_req, rdata);
            end
        end
        @(posedge clk); #1;
        dmem_ack = 0;
    endtask

    task automatic test_back_to_back;
        run_txn("b2b_0", 1, 0, 3'b101, 32'h006, 0, 32'hBEEF0000, 0,
                32'h004, 4'b0000, 0, 32'h0000BEEF);
        run_txn("b2b_1", 0, 1, 3'b000, 32'h007, 32'h000000A5, 0, 0,
                32'h004, 4'b1000, 32'hA5A5A5A5, 0);
        run_txn("b2b_2", 1, 0, 3'b001, 32'h006, 0, 32'h7FFF0000, 3,
                32'h004, 4'b0000, 0, 32'h00007FFF);
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_rdata_hold();
        test_access_err();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: %0d loads never completed, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, max BUSY cycles waiting for dmem_ack (range 1..255).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_read  input  1  load request from decode control, held stable while stall=1.
REQ-005 mem_write  input  1  store request from decode control, held stable while stall=1.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address from ALU result.
REQ-008 wdata  input  32  store data (rs2).
REQ-009 stall  output  1  freeze upstream pipeline.
REQ-010 rdata  output  32  extended load data, valid when rdata_valid=1.
REQ-011 rdata_valid  output  1  one-cycle load-complete pulse.
REQ-012 access_err  output  1  one-cycle pulse: misaligned, illegal funct3, or both requests high.
REQ-013 bus_err  output  1  one-cycle pulse: ack timeout.
REQ-014 dmem_req, dmem_we  output  1 each  memory request / write strobe, registered.
REQ-015 dmem_addr  output  32  word-aligned address (addr[1:0]=00), registered.
REQ-016 dmem_wdata  output  32 / dmem_be  output  4  lane-replicated data and byte enables, registered.
REQ-017 dmem_ack  input  1 / dmem_rdata  input  32  completion strobe and read word, sampled when dmem_ack=1.

Function
REQ-018 FSM states IDLE, BUSY, DONE; one-hot or binary encoding is implementer's choice.
REQ-019 IDLE, mem_read^mem_write=1, legal access: register access fields, drive dmem_* next cycle, go BUSY; stall=1 combinationally in this cycle.
REQ-020 Legal: funct3 in {000,001,010,100,101} for loads, {000,001,010} for stores; H/HU need addr[0]=0; W needs addr[1:0]=00.
REQ-021 IDLE, illegal access or mem_read=mem_write=1: access_err=1 that cycle, stall=0, no dmem_req, stay IDLE.
REQ-022 BUSY: dmem_req=1, stall=1, timeout counter increments each cycle without ack.
REQ-023 BUSY, dmem_ack=1: dmem_req drops next cycle; load captures extended dmem_rdata into rdata; go DONE.
REQ-024 BUSY, counter reaches ACK_TIMEOUT without ack: drop dmem_req, bus_err=1 in DONE, go DONE; late ack after timeout is ignored.
REQ-025 DONE: stall=0, rdata_valid=1 for loads without bus_err; no new request accepted this cycle; go IDLE.
REQ-026 Minimum latency: request cycle + 1 BUSY cycle (ack immediate) + DONE = stall for 2 cycles, rdata_valid on the 3rd.
REQ-027 Store enables: B be=1<<addr[1:0], wdata[7:0] replicated x4; H be=addr[1]?1100:0011, wdata[15:0] replicated x2; W be=1111.
REQ-028 Load extract: B/BU lane addr[1:0], H/HU lane addr[1]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-029 dmem_we=1 only for stores; dmem_be=0000 for loads.
REQ-030 rdata holds its value until the next completed load.

Reset
REQ-031 rst=1 immediately forces IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, rdata=0, counter=0, all pulses 0, stall=0.
REQ-032 Reset mid-BUSY abandons the transaction; ack arriving after reset release in IDLE is ignored.

Structure
REQ-033 Shared package holds funct3 size codes, FSM state encoding and the default ACK_TIMEOUT.
REQ-034 Combinational lane logic (be/wdata replication, load extraction) lives in sub-module lsu_align; FSM, counter and registers in load_store_unit.

Verification
REQ-035 SW addr=0x100, wdata=0xDEADBEEF, ack on first BUSY cycle -> dmem_addr=0x100, be=1111, we=1, stall high 2 cycles.
REQ-036 LB addr=0x203, dmem_rdata=0x80FF_FF7F -> rdata=0xFFFFFF80; LBU same -> rdata=0x00000080.
REQ-037 SH addr=0x002, wdata=0x0000ABCD -> be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x000.
REQ-038 LW addr=0x101 -> access_err pulse, no dmem_req, stall=0; mem_read=mem_write=1 -> access_err pulse.
REQ-039 ACK_TIMEOUT=4, no ack -> dmem_req high 4 cycles, bus_err pulse, rdata_valid=0, back to IDLE.
REQ-040 rst asserted in BUSY cycle 2 -> dmem_req=0 same cycle; ack after release -> no rdata_valid.
